// File: rtl/wshb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wshb_pkg
// Description : Shared widths, FSM states and response codes for wshb_s_mem.
// Revision    : 1.0 - initial release
// ============================================================================
package wshb_pkg;

    localparam int ADR_W = 32;
    localparam int DAT_W = 64;
    localparam int SEL_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        RSP_ACK = 2'd0,
        RSP_ERR = 2'd1,
        RSP_RTY = 2'd2
    } rsp_t;

    // Error always wins over a pending retry.
    function automatic rsp_t f_sel_rsp(input logic err, input logic rty);
        if (err)
            return RSP_ERR;
        else if (rty)
            return RSP_RTY;
        else
            return RSP_ACK;
    endfunction

endpackage
`default_nettype wire

// File: rtl/wshb_s_ram.sv
`default_nettype none
// ============================================================================
// Module      : wshb_s_ram
// Description : Single-port 64-bit RAM with byte-lane write enables and
//               registered read data. Contents are not reset.
// Revision    : 1.0 - initial release
// ============================================================================
module wshb_s_ram
    import wshb_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             en,
    input  logic             we,
    input  logic [IDX_W-1:0] idx,
    input  logic [SEL_W-1:0] sel,
    input  logic [DAT_W-1:0] wdat,
    output logic [DAT_W-1:0] rdat
);

    logic [DAT_W-1:0] r_mem [DEPTH];
    logic [DAT_W-1:0] r_rdat;

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                for (int b = 0; b < SEL_W; b++) begin
                    if (sel[b])
                        r_mem[idx][8*b +: 8] <= wdat[8*b +: 8];
                end
            end
            r_rdat <= r_mem[idx];
        end
    end

    assign rdat = r_rdat;

endmodule
`default_nettype wire

// File: rtl/wshb_s_mem.sv
`default_nettype none
// ============================================================================
// Module      : wshb_s_mem
// Description : Wishbone B3 classic-cycle memory slave with programmable wait
//               states and error termination. Define WSHB_S_RTY_EN to retry
//               every RTY_PERIODth error-free access.
// Revision    : 1.0 - initial release
// ============================================================================
module wshb_s_mem
    import wshb_pkg::*;
#(
    parameter int               DEPTH       = 256,
    parameter int               WAIT_STATES = 1,
    parameter logic [ADR_W-1:0] BASE_ADDR   = 32'h0000_0000,
    parameter int               RTY_PERIOD  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cyc_i,
    input  logic             stb_i,
    input  logic             we_i,
    input  logic [ADR_W-1:0] adr_i,
    input  logic [SEL_W-1:0] sel_i,
    input  logic [DAT_W-1:0] dat_i,
    output logic [DAT_W-1:0] dat_o,
    output logic             ack_o,
    output logic             err_o,
    output logic             rty_o
);

    localparam int               c_IDX_W = $clog2(DEPTH);
    localparam logic [ADR_W-1:0] c_SPAN  = ADR_W'(DEPTH * 8);

    state_t           r_state;
    logic [3:0]       r_cnt;
    logic [ADR_W-1:0] r_adr;
    logic             r_we;
    logic [SEL_W-1:0] r_sel;
    logic [DAT_W-1:0] r_dat;
    logic             r_ack;
    logic             r_err;

    logic [ADR_W-1:0]   w_off;
    logic               w_err;
    logic               w_rty_hit;
    rsp_t               w_rsp;
    logic [c_IDX_W-1:0] w_idx;
    logic               w_term;
    logic               w_ram_en;
    logic               w_ram_we;
    logic [DAT_W-1:0]   w_rdat;

    // Addresses below BASE_ADDR wrap to a huge offset, so one compare covers both bounds.
    assign w_off  = r_adr - BASE_ADDR;
    assign w_err  = (w_off >= c_SPAN) || (r_adr[2:0] != 3'b000) || (r_sel == '0);
    assign w_idx  = w_off[c_IDX_W+2:3];
    assign w_rsp  = f_sel_rsp(w_err, w_rty_hit);
    assign w_term = r_ack | r_err | rty_o;

    // Reset gating keeps a write that was in flight at reset from committing.
    assign w_ram_en = (r_state == RESP) && !rst;
    assign w_ram_we = w_ram_en && r_we && (w_rsp == RSP_ACK);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= 4'd0;
            r_adr   <= '0;
            r_we    <= 1'b0;
            r_sel   <= '0;
            r_dat   <= '0;
            r_ack   <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_ack <= 1'b0;
            r_err <= 1'b0;
            case (r_state)
                IDLE: begin
                    // A strobe still held during the termination cycle belongs to the finished access.
                    if (cyc_i && stb_i && !w_term) begin
                        r_adr   <= adr_i;
                        r_we    <= we_i;
                        r_sel   <= sel_i;
                        r_dat   <= dat_i;
                        r_cnt   <= 4'(WAIT_STATES);
                        r_state <= (WAIT_STATES == 0) ? RESP : WAIT;
                    end
                end
                WAIT: begin
                    r_cnt <= r_cnt - 4'd1;
                    if (!(cyc_i && stb_i))
                        r_state <= IDLE;
                    else if (r_cnt == 4'd1)
                        r_state <= RESP;
                end
                RESP: begin
                    r_ack   <= (w_rsp == RSP_ACK);
                    r_err   <= (w_rsp == RSP_ERR);
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef WSHB_S_RTY_EN
    localparam int c_RTY_W = (RTY_PERIOD > 1) ? $clog2(RTY_PERIOD) : 1;

    logic [c_RTY_W-1:0] r_rty_cnt;
    logic               r_rty;

    assign w_rty_hit = (r_rty_cnt == c_RTY_W'(RTY_PERIOD - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rty_cnt <= '0;
            r_rty     <= 1'b0;
        end else begin
            r_rty <= 1'b0;
            if (r_state == RESP && !w_err) begin
                r_rty     <= w_rty_hit;
                r_rty_cnt <= w_rty_hit ? '0 : r_rty_cnt + 1'b1;
            end
        end
    end

    assign rty_o = r_rty;
`else
    localparam int c_UNUSED_RTY_PERIOD = RTY_PERIOD;

    assign w_rty_hit = 1'b0;
    assign rty_o     = 1'b0;
`endif

    wshb_s_ram #(
        .DEPTH (DEPTH),
        .IDX_W (c_IDX_W)
    ) u_ram (
        .clk  (clk),
        .en   (w_ram_en),
        .we   (w_ram_we),
        .idx  (w_idx),
        .sel  (r_sel),
        .wdat (r_dat),
        .rdat (w_rdat)
    );

    assign ack_o = r_ack;
    assign err_o = r_err;
    assign dat_o = (r_ack && !r_we) ? w_rdat : '0;

endmodule
`default_nettype wire

// File: tb/tb_wshb_s_mem.sv
`default_nettype none
// ============================================================================
// Module      : tb_wshb_s_mem
// Description : Randomized self-checking bench for wshb_s_mem against an
//               array-based memory model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wshb_s_mem;

    localparam int          DEPTH      = 256;
    localparam int          WS         = 1;
    localparam int          RTY_PERIOD = 4;
    localparam logic [31:0] BASE       = 32'h0000_0000;
`ifdef WSHB_S_RTY_EN
    localparam bit RTY_EN = 1'b1;
`else
    localparam bit RTY_EN = 1'b0;
`endif

    logic        clk   = 1'b0;
    logic        rst   = 1'b1;
    logic        cyc_i = 1'b0;
    logic        stb_i = 1'b0;
    logic        we_i  = 1'b0;
    logic [31:0] adr_i = '0;
    logic [7:0]  sel_i = '0;
    logic [63:0] dat_i = '0;
    logic [63:0] dat_o;
    logic        ack_o;
    logic        err_o;
    logic        rty_o;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [63:0] model [DEPTH];
    int          ok_cnt  = 0;
    logic [63:0] last_rd;
    logic [2:0]  last_rsp;

    wshb_s_mem #(
        .DEPTH       (DEPTH),
        .WAIT_STATES (WS),
        .BASE_ADDR   (BASE),
        .RTY_PERIOD  (RTY_PERIOD)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .cyc_i (cyc_i),
        .stb_i (stb_i),
        .we_i  (we_i),
        .adr_i (adr_i),
        .sel_i (sel_i),
        .dat_i (dat_i),
        .dat_o (dat_o),
        .ack_o (ack_o),
        .err_o (err_o),
        .rty_o (rty_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // One classic-cycle access; expectations come from the array model.
    task automatic access(input logic we, input logic [31:0] adr, input logic [7:0] sel,
                          input logic [63:0] dat);
        longint      a;
        bit          err;
        int          idx;
        logic [2:0]  exp_rsp;
        logic [63:0] exp_rd;
        int          lat;
        bit          done;
        a   = longint'(adr);
        err = (a < longint'(BASE)) || (a > longint'(BASE) + DEPTH * 8 - 1)
              || (adr % 8 != 0) || (sel == 8'h00);
        idx = err ? 0 : int'((adr - BASE) / 8);
        if (err)
            exp_rsp = 3'b010;
        else if (RTY_EN && ((ok_cnt + 1) % RTY_PERIOD == 0))
            exp_rsp = 3'b100;
        else
            exp_rsp = 3'b001;
        if (!err) ok_cnt++;
        exp_rd = (!we && exp_rsp == 3'b001) ? model[idx] : 64'h0;
        if (we && exp_rsp == 3'b001)
            for (int b = 0; b < 8; b++)
                if (sel[b]) model[idx][8*b +: 8] = dat[8*b +: 8];

        @(negedge clk);
        cyc_i = 1'b1; stb_i = 1'b1; we_i = we; adr_i = adr; sel_i = sel; dat_i = dat;
        lat  = 0;
        done = 1'b0;
        while (!done && lat < 20) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
            if (ack_o || err_o || rty_o) done = 1'b1;
            else chk("dat_wait", dat_o, 64'h0);
        end
        last_rsp = {rty_o, err_o, ack_o};
        last_rd  = dat_o;
        chk("latency", 64'(lat), 64'(WS + 2));
        chk("rsp", 64'(last_rsp), 64'(exp_rsp));
        chk("rdata", last_rd, exp_rd);
        cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("term_one_cycle", 64'({rty_o, err_o, ack_o}), 64'h0);
        chk("dat_after", dat_o, 64'h0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] adr;
        logic [7:0]  sel;
        int          r;
        int          lat;

        repeat (2) @(posedge clk);
        #1;
        chk("reset_outs", {dat_o[60:0], rty_o, err_o, ack_o}, 64'h0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < DEPTH; i++)
            access(1'b1, BASE + 32'(i * 8), 8'hFF, {$urandom, $urandom});

        // Write then read
        access(1'b1, 32'h10, 8'hFF, 64'h1122334455667788);
        access(1'b0, 32'h10, 8'hFF, 64'h0);
        chk("wr_rd_0x10", last_rd, 64'h1122334455667788);

        // Byte lanes
        access(1'b1, 32'h18, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF);
        access(1'b1, 32'h18, 8'h0F, 64'h0);
        access(1'b0, 32'h18, 8'hFF, 64'h0);
        chk("byte_lanes", last_rd, 64'hFFFF_FFFF_0000_0000);

        // Error terminations leave memory untouched
        access(1'b1, 32'h800, 8'hFF, 64'hDEAD_BEEF_DEAD_BEEF);
        chk("err_range", 64'(last_rsp), 64'h2);
        access(1'b1, 32'h13, 8'hFF, 64'hDEAD_BEEF_DEAD_BEEF);
        chk("err_align", 64'(last_rsp), 64'h2);
        access(1'b1, 32'h18, 8'h00, 64'hDEAD_BEEF_DEAD_BEEF);
        chk("err_sel0", 64'(last_rsp), 64'h2);
        access(1'b0, 32'h10, 8'hFF, 64'h0);
        access(1'b0, 32'h18, 8'hFF, 64'h0);
        chk("err_no_write", last_rd, 64'hFFFF_FFFF_0000_0000);

        // Abort: cyc dropped during WAIT
        @(negedge clk);
        cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b1; adr_i = 32'h20; sel_i = 8'hFF;
        dat_i = 64'hA5A5_A5A5_A5A5_A5A5;
        @(posedge clk);
        @(negedge clk);
        cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            @(negedge clk);
            chk("abort_no_term", 64'({rty_o, err_o, ack_o}), 64'h0);
        end
        access(1'b0, 32'h20, 8'hFF, 64'h0);

        // Reset during WAIT of a write: no commit
        @(negedge clk);
        cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b1; adr_i = 32'h28; sel_i = 8'hFF;
        dat_i = 64'h5A5A_5A5A_5A5A_5A5A;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1; cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0;
        #1;
        chk("rst_wait_outs", {dat_o[60:0], rty_o, err_o, ack_o}, 64'h0);
        @(posedge clk);
        @(negedge clk);
        rst    = 1'b0;
        ok_cnt = 0;
        access(1'b0, 32'h28, 8'hFF, 64'h0);

        // Reset asserted while a read is being acknowledged
        access(1'b1, 32'h30, 8'hFF, 64'h0123_4567_89AB_CDEF);
        @(negedge clk);
        cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b0; adr_i = 32'h30; sel_i = 8'hFF;
        lat = 0;
        while (!ack_o && lat < 20) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
        chk("rst_ack_seen", 64'(ack_o), 64'h1);
        rst = 1'b1; cyc_i = 1'b0; stb_i = 1'b0;
        #1;
        chk("rst_ack_outs", 64'({rty_o, err_o, ack_o}), 64'h0);
        chk("rst_ack_dat", dat_o, 64'h0);
        @(posedge clk);
        @(negedge clk);
        rst    = 1'b0;
        ok_cnt = 0;
        access(1'b0, 32'h30, 8'hFF, 64'h0);

        // Randomized traffic
        for (int i = 0; i < 300; i++) begin
            r = int'($urandom_range(0, 9));
            if (r == 0)
                adr = $urandom;
            else if (r == 1)
                adr = BASE + 32'($urandom_range(0, DEPTH - 1) * 8) + 32'($urandom_range(1, 7));
            else if (r == 2)
                adr = BASE + 32'(DEPTH * 8) + 32'($urandom_range(0, 15) * 8);
            else
                adr = BASE + 32'($urandom_range(0, DEPTH - 1) * 8);
            sel = ($urandom_range(0, 15) == 0) ? 8'h00 : 8'($urandom);
            access(1'($urandom), adr, sel, {$urandom, $urandom});
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/wshb_s_mem.md
WSHB_S_MEM -- requirements
Module: wshb_s_mem

Interface
REQ-001 The block SHALL have parameter DEPTH, default 256, meaning the number of 64-bit memory words (a power of two, 2 to 65536).
REQ-002 The block SHALL have parameter WAIT_STATES, default 1, meaning the number of extra cycles inserted before the response (0 to 15).
REQ-003 The block SHALL have parameter BASE_ADDR, default 32'h0000_0000, meaning the byte address of word 0, aligned to DEPTH*8.
REQ-004 The block SHALL have parameter RTY_PERIOD, default 4, meaning every RTY_PERIODth accepted access is retried (used only with WSHB_S_RTY_EN).
REQ-005 Port clk, input, 1 bit: the single clock; all logic SHALL be on its rising edge.
REQ-006 Port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-007 Port cyc_i, input, 1 bit: bus cycle in progress.
REQ-008 Port stb_i, input, 1 bit: strobe.
REQ-009 Port we_i, input, 1 bit: write enable.
REQ-010 Port adr_i, input, 32 bits: byte address.
REQ-011 Port sel_i, input, 8 bits: byte lane selects.
REQ-012 Port dat_i, input, 64 bits: write data.
REQ-013 Port dat_o, output, 64 bits: read data.
REQ-014 Port ack_o, output, 1 bit: normal termination.
REQ-015 Port err_o, output, 1 bit: error termination.
REQ-016 Port rty_o, output, 1 bit: retry termination.

Function
REQ-017 The block SHALL be a Wishbone B3 classic-cycle slave, with no pipelining and no burst support.
REQ-018 The FSM SHALL have states IDLE, WAIT and RESP.
REQ-019 IDLE: when cyc_i&stb_i is sampled, the block SHALL latch adr_i, we_i, sel_i and dat_i, load the wait counter with WAIT_STATES, and go to WAIT, or to RESP if WAIT_STATES==0.
REQ-020 WAIT: the counter SHALL decrement each cycle; at 1 the FSM SHALL go to RESP; if cyc_i or stb_i is low, the FSM SHALL go to IDLE with no side effects.
REQ-021 RESP: exactly one of ack_o, err_o or rty_o SHALL be high for exactly one cycle, after which the FSM SHALL return to IDLE.
REQ-022 A back-to-back strobe SHALL be accepted no earlier than the cycle after the termination signal.
REQ-023 Latency: for strobe sampled at edge N, the termination signal SHALL be high in the cycle after edge N+1+WAIT_STATES.
REQ-024 err_o SHALL be selected when the latched address is outside [BASE_ADDR, BASE_ADDR+DEPTH*8-1], when adr[2:0]!=0, or when sel==0.
REQ-025 A write SHALL update only the bytes whose sel bit is set, committing at the edge where ack_o rises; an err or rty termination SHALL NOT modify memory.
REQ-026 A read SHALL drive the full 64-bit word on dat_o while ack_o is high; dat_o SHALL be 0 in all other cycles.
REQ-027 The word index SHALL be (adr-BASE_ADDR)>>3, truncated to log2(DEPTH) bits after the range check.
REQ-028 If cyc_i drops during RESP, the termination SHALL still complete and memory SHALL remain consistent with REQ-025.

Reset
REQ-029 Asserting rst SHALL immediately force the FSM to IDLE and drive ack_o, err_o, rty_o and dat_o to 0, and clear the wait and retry counters.
REQ-030 Memory contents SHALL NOT be cleared by reset; an in-flight write aborted by reset SHALL NOT commit.

Configuration
REQ-031 With WSHB_S_RTY_EN defined, a modulo-RTY_PERIOD counter of accepted in-range accesses SHALL force rty_o instead of ack_o on every RTY_PERIODth access, starting from the RTY_PERIODth after reset; err_o SHALL take priority over rty_o.
REQ-032 Without WSHB_S_RTY_EN, rty_o SHALL be tied to 0 and no retry counter SHALL exist.

Structure
REQ-033 Package wshb_pkg SHALL hold the width constants (ADR_W=32, DAT_W=64, SEL_W=8), the FSM state enum, and the response enum (RSP_ACK, RSP_ERR, RSP_RTY).
REQ-034 The byte-enabled storage SHALL be in sub-module wshb_s_ram (one read/write port, sel byte enables).

Verification
REQ-035 Scenario, write then read: WAIT_STATES=1, write adr 0x10, dat 0x1122334455667788, sel 0xFF, then read adr 0x10 -> ack_o 3 cycles after each strobe and dat_o=0x1122334455667788.
REQ-036 Scenario, byte lanes: write 0xFFFF...FF with sel 0xFF, then write 0 with sel 0x0F, then read -> 0xFFFFFFFF00000000.
REQ-037 Scenario, errors: access adr 0x800 (DEPTH=256), adr 0x13 and sel 0 -> err_o for one cycle each and memory unchanged.
REQ-038 Scenario, abort: cyc_i dropped during WAIT of a write to 0x20 -> no termination signal and a read of 0x20 returns its old value.
REQ-039 Scenario, reset mid-operation: rst pulsed in WAIT -> all outputs 0 within the same cycle and the next access completes normally.
REQ-040 Scenario, retry (WSHB_S_RTY_EN, RTY_PERIOD=4): 8 writes -> rty_o on the 4th and 8th, and those words are unmodified.
